// File: rtl/reorder_buffer_multiport_pkg.sv
// Shared types for the multi-issue reorder buffer: entry layout and the
// per-lane summary consumed by the retire selector.
package reorder_buffer_multiport_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_TAG_W = 4;

   typedef struct packed {
      logic [31:0] programCounter;
      logic [31:0] instructionResult;
      logic [4:0]  destinationRegister;
      logic        isStore;
      logic        ready;
      logic        busy;
   } RobEntry_;

   typedef struct packed {
      logic done;
      logic isStore;
      logic writesRegister;
   } RetireLane_;

endpackage

// File: rtl/reorder_buffer_multiport_retire_select.sv
// Head-window scan: decides which of the oldest entries retire this cycle,
// whether the head store commits, and how far head advances.
module rob_retire_select
   import reorder_buffer_multiport_pkg::*;
#(
   parameter  int unsigned RETIRE_WIDTH = 2,
   localparam int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1)
) (
   input  RetireLane_              i_window [RETIRE_WIDTH],
   input  logic [RETIRE_WIDTH-1:0] i_laneLive,
   input  logic                    i_storeCommitReady,
   output logic [RETIRE_WIDTH-1:0] o_laneFree,
   output logic [RETIRE_WIDTH-1:0] o_regWrite,
   output logic                    o_storeCommit,
   output logic [CNT_W-1:0]        o_advance
);

   logic w_scanOpen;

   always_comb begin
      o_laneFree    = '0;
      o_regWrite    = '0;
      o_storeCommit = 1'b0;
      o_advance     = '0;
      w_scanOpen    = 1'b1;
      for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
         if (w_scanOpen && i_laneLive[k] && i_window[k].done) begin
            if (i_window[k].isStore) begin
               // Stores only commit from lane 0 and always end the scan.
               if (k == 0 && i_storeCommitReady) begin
                  o_laneFree[k] = 1'b1;
                  o_storeCommit = 1'b1;
                  o_advance     = CNT_W'(1);
               end
               w_scanOpen = 1'b0;
            end else begin
               o_laneFree[k] = 1'b1;
               o_regWrite[k] = i_window[k].writesRegister;
               o_advance     = CNT_W'(k + 1);
            end
         end else begin
            w_scanOpen = 1'b0;
         end
      end
   end

endmodule

// File: rtl/reorder_buffer_multiport.sv
// Reorder buffer: in-order multi-lane allocation, out-of-order completion,
// in-order multi-lane retirement with store commit and partial squash.
module reorder_buffer_multiport
   import reorder_buffer_multiport_pkg::*;
#(
   parameter  int unsigned DEPTH          = ROB_DEPTH,
   parameter  int unsigned ISSUE_WIDTH    = 2,
   parameter  int unsigned COMPLETE_PORTS = 3,
   parameter  int unsigned RETIRE_WIDTH   = 2,
   localparam int unsigned TAG_W          = $clog2(DEPTH)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [ISSUE_WIDTH-1:0]           issueConfirm,
   input  logic [ISSUE_WIDTH*32-1:0]        issueProgramCounter,
   input  logic [ISSUE_WIDTH*5-1:0]         issueDestinationRegister,
   input  logic [ISSUE_WIDTH-1:0]           issueIsStore,
   output logic                             issueReady,
   output logic [ISSUE_WIDTH*TAG_W-1:0]     issueTag,
   input  logic [COMPLETE_PORTS-1:0]        completeValid,
   input  logic [COMPLETE_PORTS*TAG_W-1:0]  completeTag,
   input  logic [COMPLETE_PORTS*32-1:0]     completeResult,
   input  logic                             flushValid,
   input  logic [TAG_W-1:0]                 flushTag,
   output logic [RETIRE_WIDTH-1:0]          retireValid,
   output logic [RETIRE_WIDTH*5-1:0]        retireDestinationRegister,
   output logic [RETIRE_WIDTH*32-1:0]       retireResult,
   output logic [RETIRE_WIDTH*32-1:0]       retireProgramCounter,
   output logic                             storeCommitValid,
   output logic [TAG_W-1:0]                 storeCommitTag,
   input  logic                             storeCommitReady,
   output logic [TAG_W:0]                   occupancy,
   output logic                             empty,
   output logic                             full
);

   localparam int unsigned CNT_W = $clog2(RETIRE_WIDTH + 1);

   RobEntry_                r_entries [DEPTH];
   logic [TAG_W:0]          r_head;
   logic [TAG_W:0]          r_tail;

   logic [TAG_W:0]          w_occupancy;
   logic [TAG_W:0]          w_freeCount;
   logic [TAG_W:0]          w_issueCount;
   logic [TAG_W:0]          w_flushTail;
   logic [TAG_W-1:0]        w_headIdx;
   logic [TAG_W-1:0]        w_tailIdx;
   logic [TAG_W-1:0]        w_flushRel;
   logic                    w_issueReady;
   logic                    w_issueFire;
   logic [DEPTH-1:0]        w_squash;
   logic [TAG_W-1:0]        w_completeIdx [COMPLETE_PORTS];
   logic [COMPLETE_PORTS-1:0] w_completeHit;
   logic                    w_dupComplete;
   logic                    w_badFlush;

   RetireLane_              w_window [RETIRE_WIDTH];
   logic [RETIRE_WIDTH-1:0] w_laneLive;
   logic [RETIRE_WIDTH-1:0] w_laneFree;
   logic [RETIRE_WIDTH-1:0] w_regWrite;
   logic                    w_storeCommit;
   logic [CNT_W-1:0]        w_advance;

   assign w_headIdx    = r_head[TAG_W-1:0];
   assign w_tailIdx    = r_tail[TAG_W-1:0];
   assign w_occupancy  = r_tail - r_head;
   assign w_freeCount  = (TAG_W+1)'(DEPTH) - w_occupancy;
   assign w_issueReady = w_freeCount >= (TAG_W+1)'(ISSUE_WIDTH);
   assign w_issueFire  = w_issueReady && !flushValid;
   assign w_flushRel   = flushTag - w_headIdx;
   // Survivors are head..flushTag, so the new tail is rebuilt from head to keep the wrap bit right.
   assign w_flushTail  = r_head + (TAG_W+1)'(w_flushRel) + (TAG_W+1)'(1);
   assign w_badFlush   = flushValid && !r_entries[flushTag].busy;

   assign issueReady       = w_issueReady;
   assign occupancy        = w_occupancy;
   assign empty            = (w_occupancy == '0);
   assign full             = (w_occupancy == (TAG_W+1)'(DEPTH));
   assign retireValid      = w_regWrite;
   assign storeCommitValid = w_storeCommit;
   assign storeCommitTag   = w_headIdx;

   always_comb begin
      issueTag     = '0;
      w_issueCount = '0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         issueTag[i*TAG_W +: TAG_W] = w_tailIdx + TAG_W'(i);
         w_issueCount = w_issueCount + (TAG_W+1)'(issueConfirm[i]);
      end
   end

   always_comb begin
      w_squash = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
         w_squash[j] = flushValid && ((TAG_W'(j) - w_headIdx) > w_flushRel);
      end
   end

   always_comb begin
      w_completeHit = '0;
      for (int unsigned p = 0; p < COMPLETE_PORTS; p++) begin
         w_completeIdx[p] = completeTag[p*TAG_W +: TAG_W];
         w_completeHit[p] = completeValid[p] && r_entries[w_completeIdx[p]].busy
                            && !r_entries[w_completeIdx[p]].ready && !w_squash[w_completeIdx[p]];
      end
   end

   always_comb begin
      w_dupComplete = 1'b0;
      for (int unsigned p = 0; p < COMPLETE_PORTS; p++) begin
         for (int unsigned q = p + 1; q < COMPLETE_PORTS; q++) begin
            if (completeValid[p] && completeValid[q] && (w_completeIdx[p] == w_completeIdx[q]))
               w_dupComplete = 1'b1;
         end
      end
   end

   always_comb begin
      retireDestinationRegister = '0;
      retireResult              = '0;
      retireProgramCounter      = '0;
      for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
         w_window[k].done           = r_entries[w_headIdx + TAG_W'(k)].busy && r_entries[w_headIdx + TAG_W'(k)].ready;
         w_window[k].isStore        = r_entries[w_headIdx + TAG_W'(k)].isStore;
         w_window[k].writesRegister = |r_entries[w_headIdx + TAG_W'(k)].destinationRegister;
         // A flush in the same cycle limits retirement to surviving entries.
         w_laneLive[k] = !flushValid || (TAG_W'(k) <= w_flushRel);
         retireDestinationRegister[k*5 +: 5] = r_entries[w_headIdx + TAG_W'(k)].destinationRegister;
         retireResult[k*32 +: 32]            = r_entries[w_headIdx + TAG_W'(k)].instructionResult;
         retireProgramCounter[k*32 +: 32]    = r_entries[w_headIdx + TAG_W'(k)].programCounter;
      end
   end

   rob_retire_select #(
      .RETIRE_WIDTH(RETIRE_WIDTH)
   ) u_retireSelect (
      .i_window          (w_window),
      .i_laneLive        (w_laneLive),
      .i_storeCommitReady(storeCommitReady),
      .o_laneFree        (w_laneFree),
      .o_regWrite        (w_regWrite),
      .o_storeCommit     (w_storeCommit),
      .o_advance         (w_advance)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_head <= '0;
         r_tail <= '0;
         for (int unsigned j = 0; j < DEPTH; j++) r_entries[j] <= '0;
      end else begin
         r_head <= r_head + (TAG_W+1)'(w_advance);
         if (flushValid)
            r_tail <= w_flushTail;
         else if (w_issueFire)
            r_tail <= r_tail + w_issueCount;

         for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
            if (w_laneFree[k]) begin
               r_entries[w_headIdx + TAG_W'(k)].busy  <= 1'b0;
               r_entries[w_headIdx + TAG_W'(k)].ready <= 1'b0;
            end
         end

         for (int unsigned p = 0; p < COMPLETE_PORTS; p++) begin
            if (w_completeHit[p]) begin
               r_entries[w_completeIdx[p]].instructionResult <= completeResult[p*32 +: 32];
               r_entries[w_completeIdx[p]].ready             <= 1'b1;
            end
         end

         for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (w_issueFire && issueConfirm[i]) begin
               r_entries[w_tailIdx + TAG_W'(i)] <= '{
                  programCounter:      issueProgramCounter[i*32 +: 32],
                  instructionResult:   32'h0,
                  destinationRegister: issueDestinationRegister[i*5 +: 5],
                  isStore:             issueIsStore[i],
                  ready:               1'b0,
                  busy:                1'b1
               };
            end
         end

         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (w_squash[j]) begin
               r_entries[j].busy  <= 1'b0;
               r_entries[j].ready <= 1'b0;
            end
         end
      end
   end

   a_noDuplicateComplete : assert property (@(posedge clock) disable iff (reset) !w_dupComplete);
   a_flushTagBusy        : assert property (@(posedge clock) disable iff (reset) !w_badFlush);

endmodule

// File: tb/tb_reorder_buffer_multiport.sv
// Directed bench for reorder_buffer_multiport with hand-computed expectations.
module tb_reorder_buffer_multiport;

   localparam int TW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    issueConfirm = '0;
   logic [63:0]   issueProgramCounter = '0;
   logic [9:0]    issueDestinationRegister = '0;
   logic [1:0]    issueIsStore = '0;
   logic          issueReady;
   logic [7:0]    issueTag;
   logic [2:0]    completeValid = '0;
   logic [11:0]   completeTag = '0;
   logic [95:0]   completeResult = '0;
   logic          flushValid = 1'b0;
   logic [3:0]    flushTag = '0;
   logic [1:0]    retireValid;
   logic [9:0]    retireDestinationRegister;
   logic [63:0]   retireResult;
   logic [63:0]   retireProgramCounter;
   logic          storeCommitValid;
   logic [3:0]    storeCommitTag;
   logic          storeCommitReady = 1'b0;
   logic [4:0]    occupancy;
   logic          empty;
   logic          full;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   reorder_buffer_multiport #(
      .DEPTH(16), .ISSUE_WIDTH(2), .COMPLETE_PORTS(3), .RETIRE_WIDTH(2)
   ) dut (
      .clock(clock), .reset(reset),
      .issueConfirm(issueConfirm), .issueProgramCounter(issueProgramCounter),
      .issueDestinationRegister(issueDestinationRegister), .issueIsStore(issueIsStore),
      .issueReady(issueReady), .issueTag(issueTag),
      .completeValid(completeValid), .completeTag(completeTag), .completeResult(completeResult),
      .flushValid(flushValid), .flushTag(flushTag),
      .retireValid(retireValid), .retireDestinationRegister(retireDestinationRegister),
      .retireResult(retireResult), .retireProgramCounter(retireProgramCounter),
      .storeCommitValid(storeCommitValid), .storeCommitTag(storeCommitTag),
      .storeCommitReady(storeCommitReady),
      .occupancy(occupancy), .empty(empty), .full(full)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         #1;
      end
   endtask

   task automatic issue2(input logic [1:0] conf, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [4:0] rd0, input logic [4:0] rd1, input logic [1:0] st);
      issueConfirm             = conf;
      issueProgramCounter      = {pc1, pc0};
      issueDestinationRegister = {rd1, rd0};
      issueIsStore             = st;
      tick();
      issueConfirm             = '0;
      issueProgramCounter      = '0;
      issueDestinationRegister = '0;
      issueIsStore             = '0;
      #1;
   endtask

   task automatic complete3(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                            input logic [3:0] t2, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2);
      completeValid  = v;
      completeTag    = {t2, t1, t0};
      completeResult = {r2, r1, r0};
      tick();
      completeValid  = '0;
      completeTag    = '0;
      completeResult = '0;
      #1;
   endtask

   // Allocation pair used by the wrap test: pc = 0x2000 + 4*tag, rd = tag + 1.
   task automatic fill_pair(input int t);
      logic [3:0] a;
      logic [3:0] b;
      a = 4'(t);
      b = 4'(t + 1);
      issue2(2'b11, 32'h2000 + 32'(a) * 4, 32'h2000 + 32'(b) * 4, 5'(a) + 5'd1, 5'(b) + 5'd1, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] rdPair;
      idle(2);
      reset = 1'b0;
      #1;

      // reset state
      check_eq("rst_empty", empty, 1);
      check_eq("rst_occ", occupancy, 0);
      check_eq("rst_tag", issueTag, 8'h10);
      check_eq("rst_ready", issueReady, 1);
      check_eq("rst_full", full, 0);
      check_eq("rst_retire", retireValid, 0);
      check_eq("rst_store", storeCommitValid, 0);

      // two non-stores completing out of order
      issue2(2'b11, 32'h100, 32'h104, 5'd5, 5'd6, 2'b00);
      check_eq("t1_occ", occupancy, 2);
      check_eq("t1_tag", issueTag, 8'h32);
      check_eq("t1_noret0", retireValid, 0);
      complete3(3'b001, 4'd1, 4'd0, 4'd0, 32'hBEEF, 0, 0);
      check_eq("t1_noret1", retireValid, 0);
      complete3(3'b100, 4'd0, 4'd0, 4'd0, 0, 0, 32'h1234);
      check_eq("t1_ret", retireValid, 2'b11);
      check_eq("t1_rd", retireDestinationRegister, {5'd6, 5'd5});
      check_eq("t1_res", retireResult, {32'hBEEF, 32'h1234});
      check_eq("t1_pc", retireProgramCounter, {32'h104, 32'h100});
      idle(1);
      check_eq("t1_drain", occupancy, 0);
      check_eq("t1_noret2", retireValid, 0);

      // store at head held by storeCommitReady
      issue2(2'b11, 32'h300, 32'h304, 5'd3, 5'd8, 2'b01);
      complete3(3'b011, 4'd2, 4'd3, 4'd0, 32'h5555, 32'h7777, 0);
      for (int c = 0; c < 3; c++) begin
         check_eq("st_hold_ret", retireValid, 0);
         check_eq("st_hold_scv", storeCommitValid, 0);
         check_eq("st_hold_occ", occupancy, 2);
         if (c < 2) idle(1);
      end
      storeCommitReady = 1'b1;
      #1;
      check_eq("st_scv", storeCommitValid, 1);
      check_eq("st_tag", storeCommitTag, 2);
      check_eq("st_lane0", retireValid, 0);
      idle(1);
      check_eq("st_scv_once", storeCommitValid, 0);
      check_eq("st_next_ret", retireValid, 2'b01);
      check_eq("st_next_res", retireResult[31:0], 32'h7777);
      check_eq("st_next_rd", retireDestinationRegister[4:0], 5'd8);
      idle(1);
      check_eq("st_empty", empty, 1);
      storeCommitReady = 1'b0;

      // rd=0 retires silently
      issue2(2'b01, 32'h400, 0, 5'd0, 5'd0, 2'b00);
      complete3(3'b001, 4'd4, 4'd0, 4'd0, 32'h9999, 0, 0);
      check_eq("rd0_ret", retireValid, 0);
      check_eq("rd0_occ1", occupancy, 1);
      idle(1);
      check_eq("rd0_occ0", occupancy, 0);
      check_eq("rd0_empty", empty, 1);

      // fill across the wrap, starting at tag 5
      for (int p = 0; p < 5; p++) fill_pair(5 + 2 * p);
      check_eq("wr_tag", issueTag, 8'h0F);
      for (int p = 5; p < 8; p++) fill_pair(5 + 2 * p);
      check_eq("wr_full", full, 1);
      check_eq("wr_nready", issueReady, 0);
      check_eq("wr_occ16", occupancy, 16);
      check_eq("wr_tag_full", issueTag, 8'h65);
      issue2(2'b11, 32'hDEAD0000, 32'hDEAD0004, 5'd9, 5'd9, 2'b00);
      check_eq("wr_ign_occ", occupancy, 16);
      check_eq("wr_ign_tag", issueTag, 8'h65);
      complete3(3'b011, 4'd5, 4'd6, 4'd0, 32'hA005, 32'hA006, 0);
      check_eq("wr_ret56", retireValid, 2'b11);
      check_eq("wr_res56", retireResult, {32'hA006, 32'hA005});
      idle(1);
      check_eq("wr_occ14", occupancy, 14);
      check_eq("wr_ready", issueReady, 1);
      check_eq("wr_nfull", full, 0);
      complete3(3'b111, 4'd7, 4'd8, 4'd9, 32'hA007, 32'hA008, 32'hA009);
      complete3(3'b111, 4'd10, 4'd11, 4'd12, 32'hA00A, 32'hA00B, 32'hA00C);
      complete3(3'b011, 4'd13, 4'd14, 4'd0, 32'hA00D, 32'hA00E, 0);
      idle(4);
      check_eq("wr_occ6", occupancy, 6);
      check_eq("wr_wait", retireValid, 0);
      complete3(3'b011, 4'd15, 4'd0, 4'd0, 32'hA00F, 32'hA000, 0);
      check_eq("wr_ret", retireValid, 2'b11);
      rdPair = {5'd1, 5'd16};
      check_eq("wr_rd", retireDestinationRegister, rdPair);
      check_eq("wr_pc", retireProgramCounter, {32'h2000, 32'h203C});
      check_eq("wr_res", retireResult, {32'hA000, 32'hA00F});

      // reset with live entries
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check_eq("mr_occ", occupancy, 0);
      check_eq("mr_empty", empty, 1);
      check_eq("mr_tag", issueTag, 8'h10);
      check_eq("mr_ret", retireValid, 0);

      // partial squash with same-cycle completion and issue
      for (int p = 0; p < 3; p++)
         issue2(2'b11, 32'h3000 + 32'(8 * p), 32'h3004 + 32'(8 * p), 5'(10 + 2 * p), 5'(11 + 2 * p), 2'b00);
      check_eq("fl_occ6", occupancy, 6);
      flushValid               = 1'b1;
      flushTag                 = 4'd2;
      completeValid            = 3'b001;
      completeTag              = 12'h004;
      completeResult           = {64'h0, 32'hDEAD};
      issueConfirm             = 2'b11;
      issueProgramCounter      = {32'h4004, 32'h4000};
      issueDestinationRegister = {5'd20, 5'd21};
      tick();
      flushValid               = 1'b0;
      completeValid            = '0;
      completeTag              = '0;
      completeResult           = '0;
      issueConfirm             = '0;
      issueProgramCounter      = '0;
      issueDestinationRegister = '0;
      #1;
      check_eq("fl_occ3", occupancy, 3);
      check_eq("fl_tag", issueTag, 8'h43);
      check_eq("fl_ready", issueReady, 1);
      check_eq("fl_noret", retireValid, 0);
      complete3(3'b111, 4'd0, 4'd1, 4'd2, 32'h1, 32'h2, 32'h3);
      check_eq("fl_ret01", retireValid, 2'b11);
      check_eq("fl_rd01", retireDestinationRegister, {5'd11, 5'd10});
      idle(1);
      check_eq("fl_ret2", retireValid, 2'b01);
      check_eq("fl_rd2", retireDestinationRegister[4:0], 5'd12);
      check_eq("fl_res2", retireResult[31:0], 32'h3);
      idle(1);
      check_eq("fl_empty", empty, 1);
      check_eq("fl_occ0", occupancy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
